// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  localparam int IMEM_DEPTH     = 256;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    CHECK   = 3'd3,
    DONE    = 3'd4,
    ERROR   = 3'd5
  } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
// A byte moves on a clock edge only when byte_valid and byte_ready are both high;
// the source holds byte_data stable while byte_valid is high and byte_ready is low.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_word_packer.sv
// Shifts bytes MSB-first into a 32-bit word; word_full_o flags the 4th byte of a word.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        shift_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  logic [31:0] word_q;
  logic [1:0]  cnt_q;

  always_ff @(negedge clk) begin
    if (reset || clear_i) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (shift_en_i) begin
      word_q <= {word_q[23:0], byte_i};
      cnt_q  <= cnt_q + 2'd1;
    end
  end

  assign word_o      = word_q;
  assign word_full_o = shift_en_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into instruction memory and holds the CPU in reset until done.
// Optional trailing checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [ADDR_W:0] word_count,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            cpu_reset,
  output state_e          dbg_state,
  imem_loader_if.slave    bus
);

  localparam logic [ADDR_W:0] MAX_WORDS = (ADDR_W + 1)'(1) << ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d, idx_q, idx_d, idx_inc, count_clamped;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pk_clear, pk_shift, pk_full, load_go;
  logic [31:0]       pk_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d, sum_chk;
  assign sum_chk = sum_q + bus.byte_data;
`endif

  assign count_clamped = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
  assign idx_inc       = idx_q + (ADDR_W + 1)'(1);
  assign load_go       = start && !busy;

  imem_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (pk_clear),
    .shift_en_i (pk_shift),
    .byte_i     (bus.byte_data),
    .word_o     (pk_word),
    .word_full_o(pk_full)
  );

  always_ff @(negedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    pk_clear = 1'b0;
    pk_shift = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d    = sum_q;
`endif
    if (load_go) begin
      count_d  = count_clamped;
      idx_d    = '0;
      addr_d   = '0;
      pk_clear = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d    = '0;
`endif
      state_d  = (count_clamped == '0) ? DONE : COLLECT;
    end else begin
      case (state_q)
        COLLECT: begin
          pk_shift = bus.byte_valid;
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (bus.byte_valid) sum_d = sum_chk;
`endif
          // Address is captured here so it stays valid through WRITE and into DONE.
          if (pk_full) begin
            addr_d  = idx_q[ADDR_W-1:0];
            state_d = WRITE;
          end
        end
        WRITE: begin
          idx_d = idx_inc;
          if (idx_inc < count_q) begin
            state_d = COLLECT;
          end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = DONE;
`endif
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (bus.byte_valid) state_d = (sum_chk == 8'd0) ? DONE : ERROR;
        end
`endif
        default: state_d = state_q;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign busy           = (state_q == COLLECT) || (state_q == WRITE) || (state_q == CHECK);
  assign bus.byte_ready = (state_q == COLLECT) || (state_q == CHECK);
  assign err            = (state_q == ERROR);
`else
  assign busy           = (state_q == COLLECT) || (state_q == WRITE);
  assign bus.byte_ready = (state_q == COLLECT);
  assign err            = 1'b0;
`endif

  assign bus.wr_en   = (state_q == WRITE);
  assign bus.wr_addr = addr_q;
  assign bus.wr_data = pk_word;
  assign done        = (state_q == DONE);
  assign cpu_reset   = (state_q != DONE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: inputs driven on posedge, DUT acts on negedge.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [AW:0]   word_count;
  logic          busy, done, err, cpu_reset;
  state_e        dbg_state;

  imem_loader_if #(.ADDR_W(AW)) bus ();

  imem_loader #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .word_count(word_count),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cpu_reset (cpu_reset),
    .dbg_state (dbg_state),
    .bus       (bus)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  int          rd_ptr = 0;
  logic [7:0]  tb_sum;
  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] act_q[$];

  // Write monitor: records every strobe seen between DUT edges.
  always @(posedge clk) begin
    if (bus.wr_en === 1'b1) begin
      act_q.push_back({bus.wr_addr, bus.wr_data});
      wr_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    rd_ptr = act_q.size();
    exp_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_cpu_reset"}, cpu_reset, 1);
    check({tag, "_wr_en"}, bus.wr_en, 0);
    check({tag, "_byte_ready"}, bus.byte_ready, 0);
    check({tag, "_wr_addr"}, bus.wr_addr, 0);
    check({tag, "_wr_data"}, bus.wr_data, 0);
    check({tag, "_state"}, dbg_state, IDLE);
  endtask

  // Driver tasks
  task automatic pulse_start(input logic [AW:0] n);
    start = 1'b1;
    word_count = n;
    cyc();
    start = 1'b0;
    tb_sum = 8'd0;
  endtask

  task automatic send_raw(input logic [7:0] b);
    int n;
    n = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (bus.byte_ready !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    check("byte_ready", bus.byte_ready, 1);
    cyc();
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_raw(b);
    tb_sum = tb_sum + b;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (done !== 1'b1 && err !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
  endtask

  task automatic finish_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_raw(8'd0 - tb_sum);
`endif
    wait_end();
  endtask

  task automatic expect_write(input logic [AW-1:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Scoreboard drain
  task automatic check_writes(input string tag);
    check({tag, "_nwrites"}, act_q.size() - rd_ptr, exp_q.size());
    while (exp_q.size() > 0) begin
      if (rd_ptr < act_q.size()) check({tag, "_write"}, act_q[rd_ptr], exp_q[0]);
      else check({tag, "_write_missing"}, 'x, exp_q[0]);
      void'(exp_q.pop_front());
      rd_ptr++;
    end
    rd_ptr = act_q.size();
  endtask

  task automatic full_load(input logic [AW:0] n, input string tag);
    logic [7:0] b;
    pulse_start(n);
    for (int i = 0; i < IMEM_DEPTH; i++) begin
      b = 8'(4 * i);
      if (i == 100) begin
        start = 1'b1;
        word_count = 9'd5;
        cyc();
        start = 1'b0;
        check({tag, "_busy_midstart"}, busy, 1);
      end
      send_word({b, b + 8'd1, b + 8'd2, b + 8'd3});
      expect_write(8'(i), {b, b + 8'd1, b + 8'd2, b + 8'd3});
    end
    finish_load();
    check({tag, "_done"}, done, 1);
    check({tag, "_wr_addr_hold"}, bus.wr_addr, 8'hFF);
    check({tag, "_last_addr"}, act_q[act_q.size() - 1][AW+31:32], 8'hFF);
    check_writes(tag);
  endtask

  int base_cnt;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    word_count = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    tb_sum = 8'd0;
    do_reset();
    check_reset_vals("rst0");

    // Basic two-word load
    base_cnt = wr_cnt;
    pulse_start(9'd2);
    check("t1_busy", busy, 1);
    check("t1_cpu_reset", cpu_reset, 1);
    check("t1_byte_ready", bus.byte_ready, 1);
    check("t1_state", dbg_state, COLLECT);
    send_word(32'h0000_0001);
    send_word(32'h0000_0002);
    expect_write(8'd0, 32'h0000_0001);
    expect_write(8'd1, 32'h0000_0002);
    finish_load();
    check("t1_done", done, 1);
    check("t1_cpu_reset_low", cpu_reset, 0);
    check("t1_busy_low", busy, 0);
    check("t1_err", err, 0);
    check("t1_wr_addr_hold", bus.wr_addr, 1);
    check_writes("t1");

    // Restart from DONE with a stall between bytes 2 and 3
    base_cnt = wr_cnt;
    pulse_start(9'd2);
    check("t2_cpu_reset_high", cpu_reset, 1);
    check("t2_done_low", done, 0);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (3) cyc();
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(32'h0000_0002);
    expect_write(8'd0, 32'h0000_0001);
    expect_write(8'd1, 32'h0000_0002);
    finish_load();
    check("t2_done", done, 1);
    check_writes("t2");
    check("t2_pulses", wr_cnt - base_cnt, 2);
    bus.byte_valid = 1'b1;
    bus.byte_data = 8'hEE;
    repeat (3) cyc();
    bus.byte_valid = 1'b0;
    check("t2_stray_done", done, 1);
    check("t2_stray_nowrite", wr_cnt - base_cnt, 2);
    check("t2_stray_wr_data", bus.wr_data, 32'h0000_0002);
    check("t2_stray_wr_addr", bus.wr_addr, 1);

    // Zero-length load
    do_reset();
    base_cnt = wr_cnt;
    check("t3_done_before", done, 0);
    start = 1'b1;
    word_count = 9'd0;
    cyc();
    start = 1'b0;
    cyc();
    check("t3_done", done, 1);
    check("t3_busy", busy, 0);
    check("t3_cpu_reset", cpu_reset, 0);
    check("t3_nowrite", wr_cnt - base_cnt, 0);

    // Reset mid-word, also racing a start
    do_reset();
    base_cnt = wr_cnt;
    pulse_start(9'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    reset = 1'b1;
    start = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    start = 1'b0;
    cyc();
    check_reset_vals("t4_rst");
    check("t4_nowrite", wr_cnt - base_cnt, 0);
    pulse_start(9'd1);
    send_word(32'hDEAD_BEEF);
    expect_write(8'd0, 32'hDEAD_BEEF);
    finish_load();
    check("t4_done", done, 1);
    check_writes("t4");

    // Checksum pass / fail
    pulse_start(9'd1);
    send_word(32'h0102_0304);
    expect_write(8'd0, 32'h0102_0304);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_raw(8'hF6);
    wait_end();
    check("t5_done", done, 1);
    check("t5_err", err, 0);
    check_writes("t5a");
    pulse_start(9'd1);
    send_word(32'h0102_0304);
    expect_write(8'd0, 32'h0102_0304);
    send_raw(8'hF7);
    wait_end();
    check("t5_err_high", err, 1);
    check("t5_err_done", done, 0);
    check("t5_err_cpu_reset", cpu_reset, 1);
    check("t5_err_busy", busy, 0);
`else
    finish_load();
    check("t5_done", done, 1);
    check("t5_err", err, 0);
`endif
    check_writes("t5");

    // Full-depth load, then an over-range count that must clamp
    full_load(9'd256, "t6");
    full_load(9'h1FF, "t7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory address width (256 words).
REQ-002 clk  in  1  single clock; all logic on its negative edge, the same edge the instruction-fetch stage uses.
REQ-003 reset  in  1  reset is synchronous and active-high.
REQ-004 start  in  1  one-cycle pulse that begins a program load.
REQ-005 word_count  in  ADDR_W+1  number of 32-bit words to load, sampled on start.
REQ-006 byte_valid  in  1  a byte is offered on byte_data.
REQ-007 byte_data  in  8  program byte stream, most-significant byte of each word first.
REQ-008 byte_ready  out  1  loader accepts a byte this cycle.
REQ-009 wr_en  out  1  instruction-memory write strobe.
REQ-010 wr_addr  out  ADDR_W  instruction-memory word address.
REQ-011 wr_data  out  32  instruction word to write.
REQ-012 busy  out  1  load in progress.
REQ-013 done  out  1  load completed successfully.
REQ-014 err  out  1  checksum failure.
REQ-015 cpu_reset  out  1  hold for the CPU's reset input; high while memory is not validly loaded.

Function
REQ-016 States SHALL be IDLE, COLLECT, WRITE, CHECK, DONE and ERROR.
REQ-017 In IDLE, start SHALL latch word_count, clear the word index and byte counter, assert busy, and enter COLLECT.
REQ-018 word_count values of 0 SHALL go directly to DONE without any write; values above 2^ADDR_W SHALL clamp to 2^ADDR_W.
REQ-019 In COLLECT, byte_ready SHALL be 1, and a byte SHALL transfer only when byte_valid and byte_ready are both high.
REQ-020 Each transfer SHALL shift the word, so that word = {word[23:0], byte_data}.
REQ-021 The cycle after the 4th transfer SHALL be WRITE.
REQ-022 In WRITE, wr_en SHALL be 1 for exactly one cycle, with wr_addr = word index and wr_data = the assembled word; byte_ready SHALL be 0.
REQ-023 After WRITE, the index SHALL increment.
REQ-024 After WRITE, the next state SHALL be COLLECT if index < count, otherwise CHECK (macro on) or DONE (macro off).
REQ-025 In DONE: done=1, busy=0, cpu_reset=0, and wr_addr SHALL hold the last written address.
REQ-026 start in DONE or ERROR SHALL restart the load as in REQ-017; cpu_reset SHALL go high the cycle after start.
REQ-027 start while busy SHALL be ignored.
REQ-028 byte_valid outside COLLECT/CHECK SHALL be ignored, with no transfer.
REQ-029 The index SHALL never exceed 2^ADDR_W-1 on wr_addr; the final write of a full load is address 2^ADDR_W-1.

Reset
REQ-030 reset SHALL force IDLE; wr_en, byte_ready, busy, done, err, wr_addr, wr_data, the index, the byte counter and the checksum SHALL all be 0, and cpu_reset SHALL be 1.
REQ-031 reset SHALL take priority over start and over any in-flight transfer; a partially assembled word SHALL be discarded, with no write.

Configuration
REQ-032 With IMEM_LOADER_CHECKSUM_EN defined, an 8-bit running sum mod 256 SHALL cover all data bytes.
REQ-033 With IMEM_LOADER_CHECKSUM_EN defined, CHECK SHALL assert byte_ready and accept one checksum byte.
REQ-034 With IMEM_LOADER_CHECKSUM_EN defined, if (sum + checksum byte) mod 256 == 0 the next state SHALL be DONE; otherwise it SHALL be ERROR, with err=1, done=0, cpu_reset=1 and busy=0.
REQ-035 Without IMEM_LOADER_CHECKSUM_EN, CHECK, ERROR and the sum logic SHALL be absent, and err SHALL be tied to 0.

Structure
REQ-036 Package imem_loader_pkg SHALL hold the state enum and the constants IMEM_DEPTH=256 and BYTES_PER_WORD=4.
REQ-037 The byte shift register and 2-bit byte counter SHALL be sub-module imem_word_packer, with outputs word[31:0] and word_full.

Verification
REQ-038 Reset, then start with word_count=2 and bytes 00 00 00 01 00 00 00 02 -> writes (0,0x00000001) and (1,0x00000002), then done=1 and cpu_reset=0.
REQ-039 Same load with byte_valid low for 3 cycles between the 2nd and 3rd bytes -> same writes, wr_en pulses exactly 2 times, and no extra byte is consumed.
REQ-040 word_count=0 -> no wr_en, and done=1 two cycles after start.
REQ-041 reset asserted after 2 bytes of word 0 -> outputs return to reset values, no write; a fresh load of word_count=1 with DEADBEEF -> write (0,0xDEADBEEF).
REQ-042 Checksum on, word_count=1, bytes 01 02 03 04 then 0xF6 -> done=1; the same with 0xF7 -> err=1 and cpu_reset=1.
REQ-043 word_count=256 with an incrementing pattern -> last write is addr 0xFF; start pulsed mid-load -> ignored.
